// File: rtl/pulse_stretch.sv
// Stretches a single-cycle tick into a registered level pulse of HIGH_CYCLES,
// followed by a forced low gap. Define PULSE_STRETCH_RETRIGGER_EN to extend the pulse on ticks seen while high.
module pulse_stretch #(
  parameter int W           = 8,
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  output logic level,
  output logic busy,
  output logic drop
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  localparam logic [W-1:0] HIGH_LOAD = W'(HIGH_CYCLES - 1);
  // LOW_CYCLES=0 never enters LOW; keep the load value in range anyway.
  localparam logic [W-1:0] LOW_LOAD  = W'((LOW_CYCLES > 0) ? (LOW_CYCLES - 1) : 0);

  state_e         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic           level_q, level_d;
  logic           busy_q, busy_d;
  logic           drop_q, drop_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = HIGH;
          cnt_d   = HIGH_LOAD;
        end
      end
      HIGH: begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
        if (tick) begin
          cnt_d = HIGH_LOAD;
        end else if (cnt_q == '0) begin
`else
        drop_d = tick;
        if (cnt_q == '0) begin
`endif
          if (LOW_CYCLES == 0) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = LOW;
            cnt_d   = LOW_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      LOW: begin
        drop_d = tick;
        if (cnt_q == '0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == HIGH);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  assign level = level_q;
  assign busy  = busy_q;
  assign drop  = drop_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Self-checking bench for pulse_stretch: default instance and HIGH=1/LOW=0 instance
// compared against a timing-window reference model.
module tb_pulse_stretch;

`ifdef PULSE_STRETCH_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic clk;
  logic reset;
  logic tick;
  logic [1:0] lv, bz, dr;

  int errors = 0;
  int checks = 0;
  int m = 0;

  int hc[2] = '{4, 1};
  int lc[2] = '{2, 0};
  int hi_until[2];
  int busy_until[2];
  int free_at[2];
  logic exp_drop[2];

  pulse_stretch #(.W(8), .HIGH_CYCLES(4), .LOW_CYCLES(2)) u_def (
    .clk(clk), .reset(reset), .tick(tick), .level(lv[0]), .busy(bz[0]), .drop(dr[0])
  );

  pulse_stretch #(.W(4), .HIGH_CYCLES(1), .LOW_CYCLES(0)) u_min (
    .clk(clk), .reset(reset), .tick(tick), .level(lv[1]), .busy(bz[1]), .drop(dr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0b expected=%0b", tag, m, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      hi_until[i]   = -1;
      busy_until[i] = -1;
      free_at[i]    = 0;
      exp_drop[i]   = 1'b0;
    end
  endtask

  // Pulse windows in absolute edge numbers: an accepted tick at edge n is high on
  // edges n..n+H-1, busy through n+H+L-1, and the next tick is accepted from n+H+L+1.
  task automatic model_edge(input int i, input logic t);
    exp_drop[i] = 1'b0;
    if (m >= free_at[i]) begin
      if (t) begin
        hi_until[i]   = m + hc[i] - 1;
        busy_until[i] = hi_until[i] + lc[i];
        free_at[i]    = hi_until[i] + lc[i] + 2;
      end
    end else if (RETRIG && t && (m - 1 <= hi_until[i])) begin
      hi_until[i]   = m + hc[i] - 1;
      busy_until[i] = hi_until[i] + lc[i];
      free_at[i]    = hi_until[i] + lc[i] + 2;
    end else begin
      exp_drop[i] = t;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("level%0d", i), lv[i], (m <= hi_until[i]));
      check($sformatf("busy%0d", i),  bz[i], (m <= busy_until[i]));
      check($sformatf("drop%0d", i),  dr[i], exp_drop[i]);
    end
  endtask

  task automatic step(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    if (!reset) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) model_edge(i, t);
    end
    check_all();
    m++;
  endtask

  initial begin
    reset = 1'b0;
    tick  = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_level", lv[i], 1'b0);
      check("rst_busy",  bz[i], 1'b0);
      check("rst_drop",  dr[i], 1'b0);
    end
    step(1'b0);
    step(1'b1);
    reset = 1'b1;

    // single tick
    step(1'b0);
    step(1'b1);
    for (int k = 0; k < 10; k++) step(1'b0);

    // tick held high
    for (int k = 0; k < 20; k++) step(1'b1);
    for (int k = 0; k < 8; k++) step(1'b0);

    // second tick two edges into the pulse
    step(1'b1);
    step(1'b0);
    step(1'b1);
    for (int k = 0; k < 10; k++) step(1'b0);

    // asynchronous reset while high
    step(1'b1);
    step(1'b0);
    #3;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("async_level", lv[i], 1'b0);
      check("async_busy",  bz[i], 1'b0);
      check("async_drop",  dr[i], 1'b0);
    end
    step(1'b1);
    step(1'b0);
    reset = 1'b1;
    step(1'b1);
    for (int k = 0; k < 8; k++) step(1'b0);

    // random traffic, alternating sparse and dense phases
    for (int k = 0; k < 400; k++) begin
      if ((k / 50) % 2 == 0) step(logic'($urandom_range(0, 3) == 0));
      else                   step(logic'($urandom_range(0, 3) != 0));
    end
    for (int k = 0; k < 10; k++) step(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
